// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer sequencing slice.
package fb_pkg;

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;
  localparam int unsigned COORD_W       = 10;

  typedef logic [COORD_W-1:0] fb_coord_t;

  typedef enum logic [2:0] {
    CLEAR,
    DRAW,
    DRAIN,
    DONE
  } fseq_state_t;

  // Saturating increment for the missed-frame counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fb_clear_scanner.sv
// Raster-order x/y counter used to sweep the back buffer during CLEAR.
// x/y is the coordinate currently being driven; x_next/y_next is the one after it.
module fb_clear_scanner
  import fb_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEFAULT,
  parameter int unsigned V_RES = V_RES_DEFAULT
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      start,
  input  logic      advance,
  output fb_coord_t x,
  output fb_coord_t y,
  output fb_coord_t x_next,
  output fb_coord_t y_next,
  output logic      last
);

  localparam fb_coord_t XMax = fb_coord_t'(H_RES - 1);
  localparam fb_coord_t YMax = fb_coord_t'(V_RES - 1);

  fb_coord_t x_q, y_q;

  // Next raster position and end-of-scan flag.
  always_comb begin
    last   = (x_q == XMax) && (y_q == YMax);
    x_next = x_q + fb_coord_t'(1);
    y_next = y_q;
    if (x_q == XMax) begin
      x_next = '0;
      y_next = (y_q == YMax) ? '0 : y_q + fb_coord_t'(1);
    end
  end

  // Counter state: start (swap) rewinds to the origin.
  always_ff @(posedge Clk) begin
    if (Reset || start) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      x_q <= x_next;
      y_q <= y_next;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/frame_sequencer.sv
// Sequences the back buffer of the ping-pong frame buffer: clear, rasterizer draw,
// drain of the last data beat, then hold frame_done until a swap on frame_clk.
module frame_sequencer
  import fb_pkg::*;
#(
  parameter int unsigned H_RES     = H_RES_DEFAULT,
  parameter int unsigned V_RES     = V_RES_DEFAULT,
  parameter logic        CLEAR_VAL = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk_rising_edge,
  input  logic        px_valid,
  output logic        px_ready,
  input  fb_coord_t   px_x,
  input  fb_coord_t   px_y,
  input  logic        px_data,
  input  logic        render_done,
  output logic        frame_start,
  output fb_coord_t   DrawX,
  output fb_coord_t   DrawY,
  output logic        draw_data,
  output logic        frame_done,
  output logic [15:0] missed_frames
);

  fseq_state_t state_q;
  fb_coord_t   draw_x_q, draw_y_q;
  logic        draw_data_q;
  logic        pend_q, pend_data_q;
  logic        px_ready_q, frame_start_q, frame_done_q;
  logic        drain_cnt_q;
  logic [15:0] missed_q;

  fb_coord_t scan_x, scan_y, scan_x_next, scan_y_next;
  logic      scan_last, scan_start, scan_advance;
  logic      accept, in_range, swap;

  // Handshake, range and swap decode.
  always_comb begin
    accept       = px_valid && px_ready_q;
    in_range     = (32'(px_x) < H_RES) && (32'(px_y) < V_RES);
    swap         = (state_q == DONE) && frame_clk_rising_edge;
    scan_start   = swap;
    scan_advance = (state_q == CLEAR) && !scan_last;
  end

  fb_clear_scanner #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_scanner (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (scan_start),
    .advance(scan_advance),
    .x      (scan_x),
    .y      (scan_y),
    .x_next (scan_x_next),
    .y_next (scan_y_next),
    .last   (scan_last)
  );

  // Main FSM with registered write port, handshake and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= CLEAR;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_data_q   <= CLEAR_VAL;
      pend_q        <= 1'b0;
      pend_data_q   <= 1'b0;
      px_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      drain_cnt_q   <= 1'b0;
      missed_q      <= '0;
    end else begin
      frame_start_q <= 1'b0;
      pend_q        <= 1'b0;
      // Data trails its address by one cycle; otherwise hold and rewrite.
      if (pend_q) draw_data_q <= pend_data_q;
      if (frame_clk_rising_edge && (state_q != DONE)) missed_q <= sat_inc16(missed_q);
      case (state_q)
        CLEAR: begin
          draw_data_q <= CLEAR_VAL;
          if (scan_last) begin
            state_q       <= DRAW;
            frame_start_q <= 1'b1;
            px_ready_q    <= 1'b1;
          end else begin
            draw_x_q <= scan_x_next;
            draw_y_q <= scan_y_next;
          end
        end
        DRAW: begin
          if (accept && in_range) begin
            draw_x_q    <= px_x;
            draw_y_q    <= px_y;
            pend_q      <= 1'b1;
            pend_data_q <= px_data;
          end
          // render_done coinciding with frame_start belongs to no frame yet.
          if (render_done && !frame_start_q) begin
            state_q     <= DRAIN;
            px_ready_q  <= 1'b0;
            drain_cnt_q <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (frame_clk_rising_edge) begin
            state_q      <= CLEAR;
            frame_done_q <= 1'b0;
            draw_x_q     <= '0;
            draw_y_q     <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign px_ready      = px_ready_q;
  assign frame_start   = frame_start_q;
  assign DrawX         = draw_x_q;
  assign DrawY         = draw_y_q;
  assign draw_data     = draw_data_q;
  assign frame_done    = frame_done_q;
  assign missed_frames = missed_q;

  logic unused_scan;
  assign unused_scan = ^{scan_x, scan_y};

endmodule
